// File: rtl/regfile_read_port.sv
// 32-entry register file with one write port and a registered dual-operand read port behind valid/ready.
// Define REGFILE_BYPASS_EN to let a same-cycle write forward its data into the captured operands.
module regfile_read_port #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2
);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic             r_rspValid;
  logic [WIDTH-1:0] r_rdata1;
  logic [WIDTH-1:0] r_rdata2;

  logic             w_accept;
  logic             w_bypass1;
  logic             w_bypass2;
  logic [WIDTH-1:0] w_op1;
  logic [WIDTH-1:0] w_op2;

  assign req_ready = !r_rspValid || rsp_ready;
  assign w_accept  = req_valid && req_ready;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      r_regs[waddr] <= wdata;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign w_bypass1 = we && (waddr != '0) && (waddr == rs1);
  assign w_bypass2 = we && (waddr != '0) && (waddr == rs2);
`else
  assign w_bypass1 = 1'b0;
  assign w_bypass2 = 1'b0;
`endif

  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    if (rs1 != '0) begin
      w_op1 = w_bypass1 ? wdata : r_regs[rs1];
    end
    if (rs2 != '0) begin
      w_op2 = w_bypass2 ? wdata : r_regs[rs2];
    end
  end

  // Operands are snapshotted at accept and held until the next accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rspValid <= 1'b0;
      r_rdata1   <= '0;
      r_rdata2   <= '0;
    end else if (w_accept) begin
      r_rspValid <= 1'b1;
      r_rdata1   <= w_op1;
      r_rdata2   <= w_op2;
    end else if (rsp_ready) begin
      r_rspValid <= 1'b0;
    end
  end

  assign rsp_valid = r_rspValid;
  assign rdata1    = r_rdata1;
  assign rdata2    = r_rdata2;

endmodule

// File: tb/tb_regfile_read_port.sv
// Directed testbench for regfile_read_port; honours REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_read_port;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  int checks;
  int failures;

  regfile_read_port #(.WIDTH(32), .DEPTH(32)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .req_valid(req_valid), .req_ready(req_ready), .rs1(rs1), .rs2(rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rdata1(rdata1), .rdata2(rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doWrite(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic doRead(input logic [4:0] a, input logic [4:0] b);
    req_valid = 1'b1; rs1 = a; rs2 = b;
    tick();
    req_valid = 1'b0;
  endtask

  function automatic logic [31:0] tpVal(input int i);
    return (i == 0) ? 32'h0 : (32'h11111111 * i);
  endfunction

  task automatic test_reset();
    reset = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    req_valid = 1'b0; rs1 = '0; rs2 = '0; rsp_ready = 1'b1;
    tick(); tick();
    checks++;
    if (rsp_valid !== 1'b0 || rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_state: valid=%b d1=%h d2=%h want 0/0/0", rsp_valid, rdata1, rdata2);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_ready: got %b want 1", req_ready);
    end
    doWrite(5'd5, 32'hDEADBEEF);
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    doRead(5'd5, 5'd0);
    checks++;
    if (rsp_valid !== 1'b1 || rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_clears_x5: valid=%b d1=%h d2=%h want 1/0/0", rsp_valid, rdata1, rdata2);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rsp_consumed: got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_basic();
    doWrite(5'd3, 32'h00000001);
    doWrite(5'd7, 32'hA5A5A5A5);
    doRead(5'd3, 5'd7);
    checks++;
    if (rsp_valid !== 1'b1 || rdata1 !== 32'h1 || rdata2 !== 32'hA5A5A5A5) begin
      failures++;
      $display("[TB] FAIL basic_read: valid=%b d1=%h d2=%h want 1/00000001/a5a5a5a5", rsp_valid, rdata1, rdata2);
    end
    doWrite(5'd0, 32'hFFFFFFFF);
    doRead(5'd0, 5'd0);
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      failures++;
      $display("[TB] FAIL x0_zero: d1=%h d2=%h want 0/0", rdata1, rdata2);
    end
    doRead(5'd7, 5'd7);
    checks++;
    if (rdata1 !== 32'hA5A5A5A5 || rdata2 !== 32'hA5A5A5A5) begin
      failures++;
      $display("[TB] FAIL same_rs: d1=%h d2=%h want a5a5a5a5/a5a5a5a5", rdata1, rdata2);
    end
    tick();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    doRead(5'd3, 5'd0);
    checks++;
    if (rsp_valid !== 1'b1 || rdata1 !== 32'h1 || req_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_start: valid=%b d1=%h rdy=%b want 1/00000001/0", rsp_valid, rdata1, req_ready);
    end
    req_valid = 1'b1; rs1 = 5'd7; rs2 = 5'd7;
    we = 1'b1; waddr = 5'd3; wdata = 32'h22222222;
    for (int i = 0; i < 4; i++) begin
      tick();
      we = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rdata1 !== 32'h1 || rdata2 !== 32'h0 || req_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL stall_hold[%0d]: valid=%b d1=%h d2=%h rdy=%b want 1/00000001/0/0", i, rsp_valid, rdata1, rdata2, req_ready);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ready_comb: got %b want 1", req_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rdata1 !== 32'h1) begin
      failures++;
      $display("[TB] FAIL stall_release: valid=%b d1=%h want 0/00000001", rsp_valid, rdata1);
    end
    doRead(5'd3, 5'd0);
    checks++;
    if (rdata1 !== 32'h22222222) begin
      failures++;
      $display("[TB] FAIL post_stall_read: got %h want 22222222", rdata1);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i < 8; i++) begin
      doWrite(5'(i), tpVal(i));
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; rs1 = 5'(i); rs2 = 5'(7 - i);
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b1 || rdata1 !== tpVal(i) || rdata2 !== tpVal(7 - i)) begin
        failures++;
        $display("[TB] FAIL b2b[%0d]: valid=%b rdy=%b d1=%h d2=%h want 1/1/%h/%h", i, rsp_valid, req_ready, rdata1, rdata2, tpVal(i), tpVal(7 - i));
      end
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_bypass();
    logic [31:0] expBypass;
`ifdef REGFILE_BYPASS_EN
    expBypass = 32'h12345678;
`else
    expBypass = 32'h0;
`endif
    we = 1'b1; waddr = 5'd9; wdata = 32'h12345678;
    req_valid = 1'b1; rs1 = 5'd9; rs2 = 5'd0;
    tick();
    we = 1'b0; req_valid = 1'b0;
    checks++;
    if (rdata1 !== expBypass || rdata2 !== 32'h0) begin
      failures++;
      $display("[TB] FAIL bypass_same_cycle: d1=%h d2=%h want %h/0", rdata1, rdata2, expBypass);
    end
    doRead(5'd9, 5'd9);
    checks++;
    if (rdata1 !== 32'h12345678 || rdata2 !== 32'h12345678) begin
      failures++;
      $display("[TB] FAIL bypass_after: d1=%h d2=%h want 12345678/12345678", rdata1, rdata2);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    rsp_ready = 1'b0;
    doRead(5'd3, 5'd7);
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rdata1 !== 32'h33333333 || rdata2 !== 32'h77777777) begin
      failures++;
      $display("[TB] FAIL midreset_pre: valid=%b d1=%h d2=%h want 1/33333333/77777777", rsp_valid, rdata1, rdata2);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      failures++;
      $display("[TB] FAIL midreset_async: valid=%b d1=%h d2=%h want 0/0/0", rsp_valid, rdata1, rdata2);
    end
    tick();
    reset = 1'b1;
    rsp_ready = 1'b1;
    doRead(5'd3, 5'd7);
    checks++;
    if (rsp_valid !== 1'b1 || rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      failures++;
      $display("[TB] FAIL midreset_lost: valid=%b d1=%h d2=%h want 1/0/0", rsp_valid, rdata1, rdata2);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_bypass();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
